// File: rtl/imem_port_arbiter.sv
// Fetch/debug arbiter for the instruction memory read port; fetch has priority, debug is starvation-protected.
// Optional address checking is enabled by defining IMEM_ARB_ADDR_CHECK_EN.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned MEM_BYTES    = 121,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       rdata,
  output logic              rerr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef IMEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              f_cand;
  logic              starved;
  logic              f_win;
  logic              d_win;
  logic              any_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              addr_misaligned;
  logic              addr_out_of_range;
  logic              addr_bad;

  // Arbitration: starved debug beats fetch, fetch beats debug otherwise; nothing is granted in reset.
  always_comb begin
    f_cand  = f_req & ~f_flush;
    starved = (starve_q == STARVE_MAX);
    d_win   = ~reset & d_req & (starved | ~f_cand);
    f_win   = ~reset & f_cand & ~d_win;
    any_gnt = f_win | d_win;
  end

  assign f_gnt = f_win;
  assign d_gnt = d_win;

  assign gnt_addr = d_win ? d_addr : f_addr;

  // Range check is done one bit wider so addr+3 cannot wrap around.
  always_comb begin
    addr_misaligned   = (gnt_addr[1:0] != 2'b00);
    addr_out_of_range = (({1'b0, gnt_addr} + EXT_W'(3)) >= EXT_W'(MEM_BYTES));
    addr_bad          = ADDR_CHECK & (addr_misaligned | addr_out_of_range);
  end

  // Memory sees the granted address only for good grants; otherwise the last one is held.
  assign mem_addr = (any_gnt & ~addr_bad) ? gnt_addr : addr_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      addr_hold_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_hold_q <= addr_hold_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next response state, captured data, address hold and starvation count.
  always_comb begin
    state_d     = IDLE;
    starve_d    = '0;
    addr_hold_d = addr_hold_q;
    rdata_d     = rdata_q;

    if (f_win) begin
      state_d = RESP_F;
    end else if (d_win) begin
      state_d = RESP_D;
    end

    if (any_gnt) begin
      rdata_d = addr_bad ? NOP_WORD : mem_rdata;
      if (!addr_bad) begin
        addr_hold_d = gnt_addr;
      end
    end

    if (d_req && !d_win) begin
      starve_d = starved ? starve_q : (starve_q + CNT_W'(1));
    end
  end

  // A response still registered when reset arrives is dropped immediately.
  assign f_rvalid = (state_q == RESP_F) & ~reset;
  assign d_rvalid = (state_q == RESP_D) & ~reset;
  assign rdata    = rdata_q;

`ifdef IMEM_ARB_ADDR_CHECK_EN
  logic rerr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rerr_q <= 1'b0;
    end else begin
      rerr_q <= any_gnt & addr_bad;
    end
  end

  assign rerr = rerr_q & ~reset;
`else
  assign rerr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: a cycle-level model predicts grants and memory address,
// queues expected responses, and a monitor compares them one cycle later.
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W       = 64;
  localparam int unsigned MEM_BYTES    = 121;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

`ifdef IMEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       rdata;
  logic              rerr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  imem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .MEM_BYTES   (MEM_BYTES),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_flush  (f_flush),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .rdata    (rdata),
    .rerr     (rerr),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-addressed memory image; addresses past the image return an address-derived pattern.
  logic [7:0] mem_bytes [0:127];

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a <= 64'd124) begin
      return {mem_bytes[a[6:0] + 7'd3], mem_bytes[a[6:0] + 7'd2],
              mem_bytes[a[6:0] + 7'd1], mem_bytes[a[6:0]]};
    end
    return a[31:0] ^ 32'h5A5A_A5A5;
  endfunction

  always_comb mem_rdata = mem_word(mem_addr);

  task automatic set_word(input int unsigned a, input logic [31:0] w);
    mem_bytes[a]     = w[7:0];
    mem_bytes[a + 1] = w[15:8];
    mem_bytes[a + 2] = w[23:16];
    mem_bytes[a + 3] = w[31:24];
  endtask

  function automatic bit addr_is_bad(input logic [ADDR_W-1:0] a);
    return (a % 4 != 0) || (a >= ADDR_W'(MEM_BYTES - 3));
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit          valid;
    bit          is_d;
    logic [31:0] data;
    bit          err;
    bit          rst;
  } resp_t;

  resp_t sb_q[$];

  // Reference state: consecutive debug denials, last good granted address, pending requests.
  int                wait_cnt   = 0;
  logic [ADDR_W-1:0] hold_addr  = '0;
  bit                hold_known = 1'b0;
  bit                last_fg    = 1'b0;
  bit                last_dg    = 1'b0;

  task automatic step(input bit rst, input bit fr, input logic [ADDR_W-1:0] fa, input bit fl,
                      input bit dr, input logic [ADDR_W-1:0] da);
    resp_t             e;
    bit                fc;
    bit                eg_f;
    bit                eg_d;
    bit                bad;
    logic [ADDR_W-1:0] ga;
    logic [ADDR_W-1:0] exp_ma;
    @(posedge clk);
    #1;
    reset   = rst;
    f_req   = fr;
    f_addr  = fa;
    f_flush = fl;
    d_req   = dr;
    d_addr  = da;
    @(negedge clk);
    fc   = fr && !fl;
    eg_d = !rst && dr && ((wait_cnt >= int'(STARVE_LIMIT)) || !fc);
    eg_f = !rst && fc && !eg_d;
    check("f_gnt", 64'(f_gnt), 64'(eg_f));
    check("d_gnt", 64'(d_gnt), 64'(eg_d));
    ga     = eg_d ? da : fa;
    bad    = CHECK_EN && (eg_f || eg_d) && addr_is_bad(ga);
    exp_ma = ((eg_f || eg_d) && !bad) ? ga : hold_addr;
    if (hold_known) check("mem_addr", mem_addr, exp_ma);
    e.valid = eg_f || eg_d;
    e.is_d  = eg_d;
    e.data  = bad ? NOP_WORD : mem_word(ga);
    e.err   = bad;
    e.rst   = rst;
    sb_q.push_back(e);
    if (rst) begin
      wait_cnt   = 0;
      hold_addr  = '0;
      hold_known = 1'b1;
    end else begin
      if (e.valid && !bad) hold_addr = ga;
      if (dr && !eg_d) wait_cnt = (wait_cnt >= int'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1;
      else wait_cnt = 0;
    end
    last_fg = eg_f;
    last_dg = eg_d;
  endtask

  // Monitor: one entry per cycle, compared against the outputs of the following cycle.
  logic [31:0] exp_rdata   = '0;
  bit          rdata_known = 1'b0;

  initial begin
    resp_t e;
    bit    live;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() == 0) continue;
      e = sb_q.pop_front();
      if (e.rst) begin
        exp_rdata   = '0;
        rdata_known = 1'b1;
      end else if (e.valid) begin
        exp_rdata = e.data;
      end
      live = e.valid && !reset;
      check("f_rvalid", 64'(f_rvalid), 64'(live && !e.is_d));
      check("d_rvalid", 64'(d_rvalid), 64'(live && e.is_d));
      if (rdata_known) check("rdata", 64'(rdata), 64'(exp_rdata));
      check("rerr", 64'(rerr), 64'(live && e.err));
    end
  end

  function automatic logic [ADDR_W-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return ADDR_W'($urandom_range(0, 127));
    if (r == 1) return ($urandom_range(0, 1) == 0) ? ADDR_W'(120) : {32'hFFFF_FFFF, $urandom()};
    return ADDR_W'($urandom_range(0, 29) * 4);
  endfunction

  initial begin
    bit                pend_f;
    bit                pend_d;
    logic [ADDR_W-1:0] cur_fa;
    logic [ADDR_W-1:0] cur_da;
    bit                fl;
    bit                rs;

    reset   = 1'b1;
    f_req   = 1'b0;
    f_addr  = '0;
    f_flush = 1'b0;
    d_req   = 1'b0;
    d_addr  = '0;
    for (int i = 0; i < 128; i++) mem_bytes[i] = 8'($urandom());
    set_word(0,  32'h0050_0993);
    set_word(4,  32'h0734_0663);
    set_word(8,  32'h0000_0493);
    set_word(12, 32'h0000_0513);
    set_word(16, 32'hfff9_8313);

    // Reset and idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back fetch
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 1, 8, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Starvation: debug wins on the fifth contested cycle, then fetch resumes
    step(0, 1, 20, 0, 1, 12);
    step(0, 1, 24, 0, 1, 12);
    step(0, 1, 28, 0, 1, 12);
    step(0, 1, 32, 0, 1, 12);
    step(0, 1, 36, 0, 1, 12);
    step(0, 1, 36, 0, 0, 0);
    step(0, 1, 40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Flush hands the cycle to debug; flush without a fetch request is inert
    step(0, 1, 44, 1, 1, 16);
    step(0, 0, 48, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Reset mid-operation
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Address check corners
    step(0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 120, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 116);
    step(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(0, 1, 12, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic; requesters hold address until granted
    pend_f = 1'b0;
    pend_d = 1'b0;
    cur_fa = '0;
    cur_da = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend_f && $urandom_range(0, 3) != 0) begin
        pend_f = 1'b1;
        cur_fa = rand_addr();
      end
      if (!pend_d && $urandom_range(0, 2) == 0) begin
        pend_d = 1'b1;
        cur_da = rand_addr();
      end
      fl = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(rs, pend_f, cur_fa, fl, pend_d, cur_da);
      if (last_fg) pend_f = 1'b0;
      if (last_dg) pend_d = 1'b0;
    end

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
